// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream merger with one registered output stage.
// Arbitration is either a fixed select or round-robin starting after the last served channel.
module stream_mux_rr #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      rr_mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               xfer_cnt
);

    localparam logic [SEL_W-1:0] LastInit = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] last_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_ch_q;
    logic             out_valid_q;
    logic [15:0]      xfer_cnt_q;

    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (!rr_mode) begin
            // Out-of-range sel matches no channel, so it never grants.
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_valid && sel == SEL_W'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(i);
                end
            end
        end else begin
            // Search order last+1, last+2, ... wrapping; first valid channel wins.
            for (int k = 1; k <= NUM_CH; k++) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!grant_valid && in_valid[i] &&
                        i == (int'(last_q) + k) % NUM_CH) begin
                        grant_valid = 1'b1;
                        grant       = SEL_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = !rst && load_en && grant_valid && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            xfer_cnt_q  <= '0;
            last_q      <= LastInit;
        end else begin
            if (out_valid_q && out_ready) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            if (load_en) begin
                if (grant_valid) begin
                    out_data_q  <= grant_data;
                    out_ch_q    <= grant;
                    out_valid_q <= 1'b1;
                    last_q      <= grant;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with a valid/ready handshake on every input and on the output, one registered output stage, and a selectable fixed-select or round-robin arbitration mode. It generalises the combinational single-bit selector into a multi-bit, back-pressure-aware channel merger. It sits between several producer streams and a single consumer.

## Interface
- NUM_CH, 4: number of input channels, ≥2.
- WIDTH, 8: data width per channel, ≥1.
- SEL_W, $clog2(NUM_CH): select/channel-index width, minimum 1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_data  input  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready. Combinational.
- sel  input  SEL_W  channel index used in fixed mode.
- rr_mode  input  1  0 = fixed select via sel, 1 = round-robin.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- xfer_cnt  output  16  count of completed output transfers.

## Operation
- load_en = !out_valid | out_ready. The output register accepts a new beat only when load_en is 1.
- Grant, combinational:
  - Fixed mode: grant = sel when sel < NUM_CH and in_valid[sel] = 1. Otherwise there is no grant. An out-of-range sel never grants.
  - Round-robin mode: search channels in order last+1, last+2, … mod NUM_CH. Grant the first channel with in_valid = 1. If no channel is valid, there is no grant.
- in_ready[i] = !rst & load_en & grant_valid & (grant == i). At most one in_ready bit is high in any cycle.
- Input transfer on channel i when in_valid[i] & in_ready[i]. At that edge:
  - out_data <= in_data[i]
  - out_ch <= i
  - out_valid <= 1
  - last <= i
- If load_en = 1 and there is no grant: out_valid <= 0. out_data and out_ch hold their previous values.
- If out_valid & !out_ready (stall): out_data, out_ch and out_valid hold. Changes on sel, rr_mode or in_* have no effect on the output register.
- last is updated on every transfer in both modes. A switch into round-robin continues from the most recently served channel.
- Output transfer when out_valid & out_ready. Each output transfer increments xfer_cnt by 1, wrapping from 16'hFFFF to 0.
- Reset values, applied at the clock edge while rst = 1 and taking priority over everything else:
  - out_valid = 0, out_data = 0, out_ch = 0, xfer_cnt = 0
  - last = NUM_CH-1, so the first round-robin search starts at channel 0
  - in_ready held at 0 while rst = 1
- Reset asserted mid-stall drops the pending output beat. This is intentional: there is no flush.

## Timing
- Latency: input transfer at edge N makes data visible on out_data, with out_valid high, after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready stays 1 and a grant exists every cycle.
- Simultaneous output transfer and new input transfer in the same cycle: the register reloads with the new beat and out_valid stays 1 (no bubble). xfer_cnt still increments.
- in_ready depends combinationally on out_ready, in_valid, sel and rr_mode. There is no combinational path from any input to out_data, out_valid or out_ch.
- Producers must hold in_data[i] stable while in_valid[i] = 1 and in_ready[i] = 0. Producers must not drop in_valid before the transfer.

## Test plan
- Reset, then fixed-mode select (NUM_CH = 4, WIDTH = 8):
  - Stimulus: hold rst for 2 cycles, then set rr_mode = 0, sel = 2, in_valid = 4'b0100, channel 2 data = 8'h5A, out_ready = 1.
  - Required: out_valid = 0 and xfer_cnt = 0 during reset. in_ready = 4'b0100. One cycle later out_data = 8'h5A, out_ch = 2, out_valid = 1.
- Round-robin fairness:
  - Stimulus: rr_mode = 1, in_valid = 4'b1111 constant, data = {8'h33, 8'h22, 8'h11, 8'h00}, out_ready = 1.
  - Required: out_ch sequence 0, 1, 2, 3, 0, 1 on consecutive cycles. out_data tracks the channel. xfer_cnt increments every cycle.
- Round-robin skip:
  - Stimulus: rr_mode = 1, in_valid = 4'b1010.
  - Required: out_ch alternates 1, 3, 1, 3. Channels 0 and 2 never see in_ready.
- Back-pressure:
  - Stimulus: load one beat on channel 1 with data 8'hA5, then out_ready = 0 for 3 cycles while sel changes to 3 and in_data changes.
  - Required: out_data = 8'hA5, out_ch = 1, out_valid = 1 held. in_ready = 0. xfer_cnt unchanged. On out_ready = 1, the next beat comes from channel 3.
- No grant and out-of-range select:
  - Stimulus: fixed mode with sel = 1 and in_valid[1] = 0, then NUM_CH = 3 instance with sel = 3.
  - Required: out_valid drops to 0 after the current beat is consumed. in_ready = 0 on all channels.
- Counter wrap and mid-stream reset:
  - Stimulus: force 65537 output transfers; then assert rst during a stall.
  - Required: xfer_cnt reads 16'h0001 after the 65537th transfer. After the reset edge, out_valid = 0, xfer_cnt = 0, and the next round-robin grant is channel 0.
